// File: rtl/rr_pull_arbiter_pkg.sv
// Shared definitions for the round-robin pull arbiter: FSM state encoding and
// a constant-function width helper.
package rr_pull_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DELIVER = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  // Index width for n items; a single item still gets one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pull_arbiter_picker.sv
// Combinational round-robin selector: first set request strictly after
// last_grant, wrapping around.
module rr_grant_picker
  import rr_pull_arbiter_pkg::*;
#(
  parameter int unsigned num_req = 4,
  parameter int unsigned gw      = clog2(num_req)
) (
  input  logic [num_req-1:0] req_i,
  input  logic [gw-1:0]      last_grant_i,
  output logic [gw-1:0]      grant_o,
  output logic               any_req_o
);

  logic [gw-1:0] idx;

  always_comb begin
    grant_o   = '0;
    any_req_o = 1'b0;
    idx       = '0;
    for (int unsigned k = 1; k <= num_req; k++) begin
      idx = gw'((32'(last_grant_i) + k) % num_req);
      if (!any_req_o && req_i[idx]) begin
        any_req_o = 1'b1;
        grant_o   = idx;
      end
    end
  end

endmodule

// File: rtl/rr_pull_arbiter.sv
// Round-robin arbiter: several level-requesting consumers share one pulling
// upstream source; each grant fetches one word and acks the winner.
module rr_pull_arbiter
  import rr_pull_arbiter_pkg::*;
#(
  parameter int unsigned data_width = 32,
  parameter int unsigned num_req    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [num_req-1:0]          req_i,
  output logic [num_req-1:0]          ack_o,
  output logic [data_width-1:0]       dout,
  output logic                        up_req,
  input  logic                        up_ack,
  input  logic [data_width-1:0]       up_din,
  output logic [clog2(num_req)-1:0]   grant_id,
  output logic                        busy,
  output logic [31:0]                 served,
  output logic                        proto_err
);

  localparam int unsigned   gw        = clog2(num_req);
  localparam logic [gw-1:0] LAST_INIT = gw'(num_req - 1);

  arb_state_e              state_q;
  logic [num_req-1:0]      ack_q;
  logic [data_width-1:0]   dout_q;
  logic                    up_req_q;
  logic [gw-1:0]           grant_q;
  logic [gw-1:0]           last_q;
  logic [31:0]             served_q;
  logic                    perr_q;
  logic [gw-1:0]           pick;
  logic                    any_req;

  rr_grant_picker #(
    .num_req(num_req),
    .gw     (gw)
  ) u_picker (
    .req_i       (req_i),
    .last_grant_i(last_q),
    .grant_o     (pick),
    .any_req_o   (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ack_q    <= '0;
      dout_q   <= '0;
      up_req_q <= 1'b0;
      grant_q  <= '0;
      last_q   <= LAST_INIT;
      served_q <= '0;
      perr_q   <= 1'b0;
    end else begin
      ack_q <= '0;
      if (up_ack && state_q != ST_FETCH) perr_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            grant_q  <= pick;
            up_req_q <= 1'b1;
            state_q  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // ack is raised on the same edge as the capture so it lands in DELIVER
          if (up_ack) begin
            up_req_q       <= 1'b0;
            dout_q         <= up_din;
            ack_q[grant_q] <= 1'b1;
            state_q        <= ST_DELIVER;
          end
        end
        ST_DELIVER: begin
          last_q   <= grant_q;
          served_q <= served_q + 32'd1;
          state_q  <= ST_RELEASE;
        end
        ST_RELEASE: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack_o     = ack_q;
  assign dout      = dout_q;
  assign up_req    = up_req_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q != ST_IDLE);
  assign served    = served_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_rr_pull_arbiter.sv
// Randomized and directed bench for rr_pull_arbiter against a transfer-level
// reference model kept in the bench.
module tb_rr_pull_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned NR    = 4;
  localparam int unsigned GW    = 2;
  localparam int unsigned ITEMS = 600;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req_i = '0;
  logic [NR-1:0] ack_o;
  logic [DW-1:0] dout;
  logic          up_req;
  logic          up_ack = 1'b0;
  logic [DW-1:0] up_din = '0;
  logic [GW-1:0] grant_id;
  logic          busy;
  logic [31:0]   served;
  logic          proto_err;

  rr_pull_arbiter #(
    .data_width(DW),
    .num_req   (NR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_i),
    .ack_o    (ack_o),
    .dout     (dout),
    .up_req   (up_req),
    .up_ack   (up_ack),
    .up_din   (up_din),
    .grant_id (grant_id),
    .busy     (busy),
    .served   (served),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  int unsigned fail_rate = 0;
  logic [31:0] prod_val = '0;
  bit          ack_block = 1'b0;
  bit          inj_ack = 1'b0;

  // Reference model: one transfer in flight, described by what it is waiting for.
  bit          m_wait, m_deliv, m_rel, m_perr;
  int unsigned m_grant, m_last;
  logic [31:0] m_dout, m_served;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned rr_next(input logic [NR-1:0] r, input int unsigned last);
    int unsigned sel;
    sel = last;
    for (int k = NR; k >= 1; k--)
      if (r[(last + k) % NR]) sel = (last + k) % NR;
    return sel;
  endfunction

  task automatic model_step(input bit r_rst, input logic [NR-1:0] r, input bit a, input logic [31:0] d);
    if (r_rst) begin
      m_wait = 0; m_deliv = 0; m_rel = 0; m_perr = 0;
      m_grant = 0; m_last = NR - 1; m_dout = '0; m_served = '0;
    end else begin
      if (a && !m_wait) m_perr = 1;
      if (m_rel) m_rel = 0;
      else if (m_deliv) begin
        m_deliv = 0; m_rel = 1; m_last = m_grant; m_served = m_served + 1;
      end else if (m_wait) begin
        if (a) begin m_wait = 0; m_dout = d; m_deliv = 1; end
      end else if (r != '0) begin
        m_grant = rr_next(r, m_last); m_wait = 1;
      end
    end
  endtask

  task automatic cycle(input logic [NR-1:0] r);
    bit a, ur;
    logic [31:0] d;
    logic [NR-1:0] e_ack;
    ur = (up_req === 1'b1);
    a  = (ur && !ack_block && ($urandom_range(99) >= fail_rate)) || inj_ack;
    d  = (inj_ack && !ur) ? 32'hDEAD_BEEF : prod_val;
    req_i = r; up_ack = a; up_din = d;
    @(posedge clk); #1;
    cyc++;
    if (a && ur && !rst) prod_val++;
    model_step(rst, r, a, d);
    e_ack = '0;
    if (m_deliv) e_ack[m_grant] = 1'b1;
    chk("ack_o", ack_o, e_ack);
    chk("up_req", up_req, m_wait);
    chk("dout", dout, m_dout);
    chk("served", served, m_served);
    chk("grant_id", grant_id, m_grant);
    chk("busy", busy, m_wait | m_deliv | m_rel);
    chk("proto_err", proto_err, m_perr);
  endtask

  task automatic run_until_ack(input logic [NR-1:0] r, input string tag);
    int unsigned n;
    n = 0;
    do begin
      cycle(r);
      n++;
    end while (ack_o == '0 && n < 50);
    if (ack_o == '0) chk({tag, "_timeout"}, 1, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cycle('0);
    rst = 1'b0;
    prod_val = '0;
  endtask

  initial begin
    int unsigned prev, got[NR], exp_next, n;
    logic [NR-1:0] r;

    // Reset values
    rst = 1'b1;
    repeat (3) cycle('0);
    chk("rst_ack", ack_o, 0);
    chk("rst_upreq", up_req, 0);
    chk("rst_served", served, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_dout", dout, 0);
    chk("rst_perr", proto_err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Single requester
    prod_val = 32'h2A;
    run_until_ack(4'b0100, "t30");
    chk("t30_ack", ack_o, 4'b0100);
    chk("t30_dout", dout, 32'h2A);
    chk("t30_grant", grant_id, 2);
    cycle('0);
    chk("t30_ack_one", ack_o, 0);
    chk("t30_served", served, 1);
    repeat (2) cycle('0);

    // All requesters held: strict rotation, 4-cycle spacing
    do_reset();
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      run_until_ack('1, "t31");
      chk("t31_grant", grant_id, i % NR);
      chk("t31_ack", ack_o, 64'd1 << (i % NR));
      chk("t31_dout", dout, i);
      if (i > 0) chk("t31_space", cyc - prev, 4);
      prev = cyc;
    end
    repeat (3) cycle('0);
    chk("t31_served", served, 8);

    // Granted request drops during FETCH
    cycle(4'b0011);
    chk("t32_grant0", grant_id, 0);
    ack_block = 1'b1;
    cycle(4'b0010);
    ack_block = 1'b0;
    prod_val = 32'h55;
    run_until_ack(4'b0010, "t32a");
    chk("t32_ack", ack_o, 4'b0001);
    chk("t32_dout", dout, 32'h55);
    run_until_ack(4'b0011, "t32b");
    chk("t32_next", ack_o, 4'b0010);
    chk("t32_next_grant", grant_id, 1);
    repeat (3) cycle('0);
    chk("t32_served", served, 10);

    // Stray upstream ack while idle
    inj_ack = 1'b1;
    cycle('0);
    inj_ack = 1'b0;
    cycle('0);
    chk("t33_perr", proto_err, 1);
    chk("t33_dout", dout, 32'h56);
    chk("t33_served", served, 10);

    // Reset during FETCH discards the transfer
    cycle(4'b1000);
    chk("t34_fetch", up_req, 1);
    rst = 1'b1; inj_ack = 1'b1;
    cycle(4'b1000);
    rst = 1'b0; inj_ack = 1'b0;
    chk("t34_upreq", up_req, 0);
    chk("t34_ack", ack_o, 0);
    chk("t34_served", served, 0);
    chk("t34_perr", proto_err, 0);
    run_until_ack(4'b1001, "t34");
    chk("t34_first", ack_o, 4'b0001);

    // Producer/consumer soak at two upstream failure rates
    for (int fr = 0; fr < 2; fr++) begin
      fail_rate = (fr == 0) ? 0 : 30;
      do_reset();
      for (int i = 0; i < NR; i++) got[i] = 0;
      exp_next = 0;
      n = 0;
      while ((got[0] + got[1] + got[2] + got[3]) < NR * ITEMS && n < 20 * NR * ITEMS) begin
        for (int i = 0; i < NR; i++) r[i] = (got[i] < ITEMS) && ($urandom_range(3) != 0);
        cycle(r);
        n++;
        if (ack_o != '0) begin
          for (int i = 0; i < NR; i++) if (ack_o[i]) got[i]++;
          chk("t35_data", dout, exp_next);
          exp_next++;
        end
      end
      repeat (3) cycle('0);
      for (int i = 0; i < NR; i++) chk("t35_got", got[i], ITEMS);
      chk("t35_served", served, NR * ITEMS);
      chk("t35_produced", prod_val, NR * ITEMS);
      chk("t35_perr", proto_err, 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
